// File: rtl/multicycle_control_if.sv
// Handshake/strobe bundle between the multi-cycle control unit and datapath.
// The control unit is the master: it consumes opcode/handshakes and drives strobes.
interface multicycle_control_if #(
  parameter int OPW   = 4,
  parameter int CNT_W = 16
);
  logic [OPW-1:0]   opcode;
  logic             mem_ready;
  logic             resume;
  logic             mem_read;
  logic             mem_write;
  logic             iord;
  logic             ir_write;
  logic             pc_write;
  logic             branch;
  logic             jump;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready, resume,
    output mem_read, mem_write, iord, ir_write,
    output pc_write, branch, jump, reg_dst,
    output mem_to_reg, alu_src, alu_op, reg_write,
    output halted, illegal, retired
  );

  modport slave (
    output opcode, mem_ready, resume,
    input  mem_read, mem_write, iord, ir_write,
    input  pc_write, branch, jump, reg_dst,
    input  mem_to_reg, alu_src, alu_op, reg_write,
    input  halted, illegal, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle main control: FETCH/DECODE/EXEC/MEM/WB sequencer with
// memory handshake, halt/resume, illegal-opcode flag and retire counter.
module multicycle_control #(
  parameter int             OPW      = 4,
  parameter logic [OPW-1:0] OP_ATYPE = OPW'(4'b0000),
  parameter logic [OPW-1:0] OP_LW    = OPW'(4'b1000),
  parameter logic [OPW-1:0] OP_SW    = OPW'(4'b1011),
  parameter logic [OPW-1:0] OP_BLT   = OPW'(4'b0100),
  parameter logic [OPW-1:0] OP_BGT   = OPW'(4'b0101),
  parameter logic [OPW-1:0] OP_BEQ   = OPW'(4'b0110),
  parameter logic [OPW-1:0] OP_JMP   = OPW'(4'b1100),
  parameter logic [OPW-1:0] OP_HALT  = OPW'(4'b1111),
  parameter int             CNT_W    = 16
) (
  input logic                clk,
  input logic                rst_n,
  multicycle_control_if.master ctl
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BRANCH,
    S_HALT
  } state_e;

  state_e           state_q, state_d;
  logic [OPW-1:0]   op_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             is_lw_q;
  logic             dec_alu;
  logic             dec_br;

  assign is_lw_q = (op_q == OP_LW);
  assign dec_alu = (ctl.opcode == OP_ATYPE) ||
                   (ctl.opcode == OP_LW) ||
                   (ctl.opcode == OP_SW);
  assign dec_br  = (ctl.opcode == OP_BLT) ||
                   (ctl.opcode == OP_BGT) ||
                   (ctl.opcode == OP_BEQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= ctl.opcode;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Strobes are gated by rst_n so they drop the moment reset asserts.
  always_comb begin
    state_d        = state_q;
    retire         = 1'b0;
    ctl.mem_read   = 1'b0;
    ctl.mem_write  = 1'b0;
    ctl.iord       = 1'b0;
    ctl.ir_write   = 1'b0;
    ctl.pc_write   = 1'b0;
    ctl.branch     = 1'b0;
    ctl.jump       = 1'b0;
    ctl.reg_dst    = 1'b0;
    ctl.mem_to_reg = 1'b0;
    ctl.alu_src    = 1'b0;
    ctl.alu_op     = 2'b00;
    ctl.reg_write  = 1'b0;
    ctl.halted     = 1'b0;
    ctl.illegal    = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        S_FETCH: begin
          ctl.mem_read = 1'b1;
          if (ctl.mem_ready) begin
            ctl.ir_write = 1'b1;
            ctl.pc_write = 1'b1;
            state_d      = S_DECODE;
          end
        end
        S_DECODE: begin
          unique case (1'b1)
            dec_alu: state_d = S_EXEC;
            dec_br:  state_d = S_BRANCH;
            (ctl.opcode == OP_JMP): begin
              ctl.jump     = 1'b1;
              ctl.pc_write = 1'b1;
              retire       = 1'b1;
              state_d      = S_FETCH;
            end
            (ctl.opcode == OP_HALT): begin
              retire  = 1'b1;
              state_d = S_HALT;
            end
            default: begin
              ctl.illegal = 1'b1;
              state_d     = S_FETCH;
            end
          endcase
        end
        S_BRANCH: begin
          ctl.alu_op = 2'b01;
          ctl.branch = 1'b1;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end
        S_EXEC: begin
          if (op_q == OP_ATYPE) begin
            ctl.alu_op = 2'b11;
            state_d    = S_WB;
          end else begin
            ctl.alu_op  = 2'b10;
            ctl.alu_src = 1'b1;
            state_d     = S_MEM;
          end
        end
        S_MEM: begin
          ctl.iord      = 1'b1;
          ctl.mem_read  = is_lw_q;
          ctl.mem_write = !is_lw_q;
          if (ctl.mem_ready) begin
            retire  = !is_lw_q;
            state_d = is_lw_q ? S_WB : S_FETCH;
          end
        end
        S_WB: begin
          ctl.reg_write  = 1'b1;
          ctl.mem_to_reg = is_lw_q;
          ctl.reg_dst    = !is_lw_q;
          retire         = 1'b1;
          state_d        = S_FETCH;
        end
        S_HALT: begin
          ctl.halted = 1'b1;
          if (ctl.resume) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign ctl.retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction phase model with random
// handshake timing and input noise; a CNT_W=2 copy checks counter wrap.
module tb_multicycle_control;

  localparam logic [3:0] OP_ATYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b1000;
  localparam logic [3:0] OP_SW    = 4'b1011;
  localparam logic [3:0] OP_BLT   = 4'b0100;
  localparam logic [3:0] OP_BGT   = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [14:0] E_MR   = 15'h4000;
  localparam logic [14:0] E_MW   = 15'h2000;
  localparam logic [14:0] E_IORD = 15'h1000;
  localparam logic [14:0] E_IRW  = 15'h0800;
  localparam logic [14:0] E_PCW  = 15'h0400;
  localparam logic [14:0] E_BR   = 15'h0200;
  localparam logic [14:0] E_JMP  = 15'h0100;
  localparam logic [14:0] E_RD   = 15'h0080;
  localparam logic [14:0] E_M2R  = 15'h0040;
  localparam logic [14:0] E_SRC  = 15'h0020;
  localparam logic [14:0] E_CMP  = 15'h0008;
  localparam logic [14:0] E_ADDR = 15'h0010;
  localparam logic [14:0] E_FUNC = 15'h0018;
  localparam logic [14:0] E_RW   = 15'h0004;
  localparam logic [14:0] E_HLT  = 15'h0002;
  localparam logic [14:0] E_ILL  = 15'h0001;

  logic clk;
  logic rst_n;
  int n_checks;
  int n_fail;
  int unsigned model_cnt;
  bit noisy;

  multicycle_control_if #(.OPW(4), .CNT_W(16)) bus ();
  multicycle_control_if #(.OPW(4), .CNT_W(2))  bus2 ();

  assign bus2.opcode    = bus.opcode;
  assign bus2.mem_ready = bus.mem_ready;
  assign bus2.resume    = bus.resume;

  multicycle_control #(.CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus)
  );

  multicycle_control #(.CNT_W(2)) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] obs();
    return {bus.mem_read, bus.mem_write, bus.iord,
            bus.ir_write, bus.pc_write, bus.branch,
            bus.jump, bus.reg_dst, bus.mem_to_reg,
            bus.alu_src, bus.alu_op, bus.reg_write,
            bus.halted, bus.illegal};
  endfunction

  function automatic logic [14:0] obs2();
    return {bus2.mem_read, bus2.mem_write, bus2.iord,
            bus2.ir_write, bus2.pc_write, bus2.branch,
            bus2.jump, bus2.reg_dst, bus2.mem_to_reg,
            bus2.alu_src, bus2.alu_op, bus2.reg_write,
            bus2.halted, bus2.illegal};
  endfunction

  task automatic noise();
    if (noisy) begin
      bus.mem_ready = 1'($urandom);
      bus.resume    = 1'($urandom);
      bus.opcode    = 4'($urandom);
    end else begin
      bus.mem_ready = 1'b1;
      bus.resume    = 1'b0;
    end
  endtask

  // One clock: inputs already driven at this negedge; check, then advance.
  task automatic step(input logic [14:0] exp, input bit ret,
                      input string nm);
    #1;
    n_checks++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL %s: strobes got %h want %h", nm, obs(), exp);
    end
    n_checks++;
    if (obs2() !== exp) begin
      n_fail++;
      $display("FAIL %s_small: strobes got %h want %h", nm, obs2(), exp);
    end
    n_checks++;
    if (bus.retired !== 16'(model_cnt)) begin
      n_fail++;
      $display("FAIL %s_retired: got %0d want %0d", nm,
               bus.retired, 16'(model_cnt));
    end
    n_checks++;
    if (bus2.retired !== 2'(model_cnt)) begin
      n_fail++;
      $display("FAIL %s_retired_w2: got %0d want %0d", nm,
               bus2.retired, 2'(model_cnt));
    end
    if (ret) model_cnt++;
    @(negedge clk);
  endtask

  task automatic exec_instr(input logic [3:0] op, input int fw,
                            input int mw, input int hw);
    logic [14:0] mexp;
    bit is_lw;
    for (int i = 0; i < fw; i++) begin
      noise(); bus.mem_ready = 1'b0;
      step(E_MR, 1'b0, "fetch_wait");
    end
    noise(); bus.mem_ready = 1'b1;
    step(E_MR | E_IRW | E_PCW, 1'b0, "fetch");
    noise(); bus.opcode = op;
    if (op == OP_JMP) begin
      step(E_JMP | E_PCW, 1'b1, "decode_jmp");
    end else if (op == OP_HALT) begin
      step('0, 1'b1, "decode_halt");
      for (int i = 0; i < hw; i++) begin
        noise(); bus.resume = 1'b0;
        step(E_HLT, 1'b0, "halt_wait");
      end
      noise(); bus.resume = 1'b1;
      step(E_HLT, 1'b0, "halt_resume");
    end else if (op == OP_BLT || op == OP_BGT || op == OP_BEQ) begin
      step('0, 1'b0, "decode_br");
      noise();
      step(E_CMP | E_BR, 1'b1, "branch");
    end else if (op == OP_ATYPE) begin
      step('0, 1'b0, "decode_a");
      noise();
      step(E_FUNC, 1'b0, "exec_a");
      noise();
      step(E_RW | E_RD, 1'b1, "wb_a");
    end else if (op == OP_LW || op == OP_SW) begin
      is_lw = (op == OP_LW);
      mexp  = is_lw ? (E_MR | E_IORD) : (E_MW | E_IORD);
      step('0, 1'b0, "decode_m");
      noise();
      step(E_ADDR | E_SRC, 1'b0, "exec_m");
      for (int i = 0; i < mw; i++) begin
        noise(); bus.mem_ready = 1'b0;
        step(mexp, 1'b0, "mem_wait");
      end
      noise(); bus.mem_ready = 1'b1;
      step(mexp, !is_lw, "mem_done");
      if (is_lw) begin
        noise();
        step(E_RW | E_M2R, 1'b1, "wb_lw");
      end
    end else begin
      step(E_ILL, 1'b0, "decode_ill");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs() !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %h want 0", obs());
    end
    n_checks++;
    if (bus.retired !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_retired: got %0d want 0", bus.retired);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    model_cnt = 0;
  endtask

  task automatic test_atype();
    noisy = 1'b0;
    exec_instr(OP_ATYPE, 0, 0, 0);
    noisy = 1'b1;
  endtask

  task automatic test_lw_wait();
    exec_instr(OP_LW, 0, 3, 0);
    exec_instr(OP_SW, 1, 2, 0);
  endtask

  task automatic test_branch_jump();
    exec_instr(OP_BEQ, 0, 0, 0);
    exec_instr(OP_JMP, 0, 0, 0);
    exec_instr(OP_BLT, 0, 0, 0);
    exec_instr(OP_BGT, 2, 0, 0);
  endtask

  task automatic test_illegal();
    exec_instr(4'b0011, 0, 0, 0);
    exec_instr(4'b1110, 1, 0, 0);
  endtask

  task automatic test_halt();
    exec_instr(OP_HALT, 0, 0, 10);
    exec_instr(OP_HALT, 0, 0, 0);
  endtask

  task automatic test_wrap();
    int unsigned s;
    s = model_cnt;
    for (int i = 0; i < 4; i++) exec_instr(OP_JMP, 0, 0, 0);
    #1;
    n_checks++;
    if (bus2.retired !== 2'(s)) begin
      n_fail++;
      $display("FAIL wrap_w2: got %0d want %0d", bus2.retired, 2'(s));
    end
    n_checks++;
    if (bus.retired !== 16'(s + 4)) begin
      n_fail++;
      $display("FAIL wrap_w16: got %0d want %0d", bus.retired, 16'(s + 4));
    end
    @(negedge clk);
    noise(); bus.mem_ready = 1'b0;
    step(E_MR, 1'b0, "wrap_idle");
  endtask

  task automatic test_reset_mid_sw();
    noise(); bus.mem_ready = 1'b1;
    step(E_MR | E_IRW | E_PCW, 1'b0, "rs_fetch");
    noise(); bus.opcode = OP_SW;
    step('0, 1'b0, "rs_decode");
    noise();
    step(E_ADDR | E_SRC, 1'b0, "rs_exec");
    noise(); bus.mem_ready = 1'b0;
    step(E_MW | E_IORD, 1'b0, "rs_mem");
    bus.mem_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 15'h0) begin
      n_fail++;
      $display("FAIL async_drop: got %h want 0", obs());
    end
    n_checks++;
    if (bus.retired !== 16'h0 || bus2.retired !== 2'h0) begin
      n_fail++;
      $display("FAIL async_retired: got %0d want 0", bus.retired);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    model_cnt = 0;
    exec_instr(OP_ATYPE, 1, 0, 0);
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      exec_instr(op, $urandom_range(0, 2), $urandom_range(0, 3),
                 $urandom_range(0, 3));
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    model_cnt     = 0;
    noisy         = 1'b1;
    rst_n         = 1'b0;
    bus.opcode    = 4'h0;
    bus.mem_ready = 1'b0;
    bus.resume    = 1'b0;
    test_reset();
    test_atype();
    test_lw_wait();
    test_branch_jump();
    test_illegal();
    test_halt();
    test_wrap();
    test_reset_mid_sw();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
